// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: MIPS-style coprocessor 0 at the MEM/WB commit point.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC, decides exception
// and eret commits, and drives flush/new_pc toward instruction fetch.
// Optional feature macro: CP0_TIMER_EN adds the Compare register and the
// Count==Compare timer interrupt (Cause.TI, routed onto IP[7]).
module cp0_exc_unit #(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HW_INT_NUM-1:0] hw_int,
    input  logic                  inst_valid,
    input  logic [6:0]            exc_vec,
    input  logic                  is_eret,
    input  logic                  in_delay_slot,
    input  logic [31:0]           cur_pc,
    input  logic [31:0]           bad_addr,
    input  logic                  mtc0_we,
    input  logic [4:0]            cp0_addr,
    input  logic [31:0]           mtc0_wdata,
    output logic [31:0]           mfc0_rdata,
    output logic                  flush,
    output logic [31:0]           new_pc,
    output logic                  int_pending
);

    // Register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // exc_vec bit positions: {pc_adel, ri, ov, sys, bp, adel, ades}
    localparam int B_PC_ADEL = 6;
    localparam int B_RI      = 5;
    localparam int B_OV      = 4;
    localparam int B_SYS     = 3;
    localparam int B_BP      = 2;
    localparam int B_ADEL    = 1;
    localparam int B_ADES    = 0;

    // Divider width; a divide-by-one build keeps a single constant-zero bit.
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    // Architectural state
    logic [31:0]      badvaddr;
    logic [31:0]      count;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       status_im;
    logic             status_exl;
    logic             status_ie;
    logic             cause_bd;
    logic [4:0]       cause_code;
    logic [1:0]       ip_sw;
    logic [5:0]       ip_hw;
    logic [31:0]      epc;
    logic             ti;

    // Derived signals
    logic [5:0]  hw_ext;
    logic [7:0]  ip;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic [31:0] compare_rd;
    logic        any_exc;
    logic        exc_taken;
    logic        eret_taken;
    logic        mtc0_ok;
    logic [4:0]  exc_code;
    logic        wr_badv_pc;
    logic        wr_badv_addr;

    // Zero-extend the hardware interrupt lines onto the six IP[7:2] slots
    always_comb begin
        hw_ext                 = '0;
        hw_ext[HW_INT_NUM-1:0] = hw_int;
    end

    // Full pending vector: timer shares IP[7] with the top hardware line
    assign ip = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};

    assign int_pending = (|(ip & status_im)) & status_ie & ~status_exl;
    assign any_exc     = int_pending | (|exc_vec);
    assign exc_taken   = inst_valid & any_exc;
    assign eret_taken  = inst_valid & is_eret & ~any_exc;
    // A register write only lands from a committing instruction that did not trap.
    assign mtc0_ok     = inst_valid & mtc0_we & ~any_exc;

    // Reset forces flush low at once, independent of the commit inputs.
    assign flush  = rst & (exc_taken | eret_taken);
    assign new_pc = exc_taken ? EXC_VECTOR : epc;

    // Prioritised cause selection; also decides which BadVAddr source applies
    always_comb begin
        exc_code     = EXC_INT;
        wr_badv_pc   = 1'b0;
        wr_badv_addr = 1'b0;
        if (int_pending) begin
            exc_code = EXC_INT;
        end else if (exc_vec[B_PC_ADEL]) begin
            exc_code   = EXC_ADEL;
            wr_badv_pc = 1'b1;
        end else if (exc_vec[B_RI]) begin
            exc_code = EXC_RI;
        end else if (exc_vec[B_OV]) begin
            exc_code = EXC_OV;
        end else if (exc_vec[B_SYS]) begin
            exc_code = EXC_SYS;
        end else if (exc_vec[B_BP]) begin
            exc_code = EXC_BP;
        end else if (exc_vec[B_ADEL]) begin
            exc_code     = EXC_ADEL;
            wr_badv_addr = 1'b1;
        end else if (exc_vec[B_ADES]) begin
            exc_code     = EXC_ADES;
            wr_badv_addr = 1'b1;
        end
    end

    // Count advances once per COUNT_DIV clocks; an mtc0 load restarts the divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            div_cnt <= '0;
        end else if (mtc0_ok && cp0_addr == REG_COUNT) begin
            count   <= mtc0_wdata;
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            count   <= count + 32'd1;
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] compare;

    // Compare register; every accepted write also acknowledges the timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare <= '0;
        end else if (mtc0_ok && cp0_addr == REG_COMPARE) begin
            compare <= mtc0_wdata;
        end
    end

    // Sticky timer flag; an acknowledge in the same cycle as a match wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ti <= 1'b0;
        end else if (mtc0_ok && cp0_addr == REG_COMPARE) begin
            ti <= 1'b0;
        end else if (compare != 32'd0 && count == compare) begin
            ti <= 1'b1;
        end
    end

    assign compare_rd = compare;
`else
    assign ti         = 1'b0;
    assign compare_rd = 32'd0;
`endif

    // Status: exception entry sets EXL, eret clears it, mtc0 writes IM/EXL/IE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_im  <= '0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (exc_taken) begin
            status_exl <= 1'b1;
        end else begin
            if (mtc0_ok && cp0_addr == REG_STATUS) begin
                status_im  <= mtc0_wdata[15:8];
                status_exl <= mtc0_wdata[1];
                status_ie  <= mtc0_wdata[0];
            end
            if (eret_taken) begin
                status_exl <= 1'b0;
            end
        end
    end

    // Hardware IP bits sample the request lines every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ip_hw <= '0;
        end else begin
            ip_hw <= hw_ext;
        end
    end

    // Cause: ExcCode always follows a taken exception; BD only on first entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cause_bd   <= 1'b0;
            cause_code <= '0;
            ip_sw      <= '0;
        end else if (exc_taken) begin
            cause_code <= exc_code;
            if (!status_exl) begin
                cause_bd <= in_delay_slot;
            end
        end else if (mtc0_ok && cp0_addr == REG_CAUSE) begin
            ip_sw <= mtc0_wdata[9:8];
        end
    end

    // EPC: captured on first exception entry (nested entries keep the original)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc <= '0;
        end else if (exc_taken) begin
            if (!status_exl) begin
                epc <= in_delay_slot ? (cur_pc - 32'd4) : cur_pc;
            end
        end else if (mtc0_ok && cp0_addr == REG_EPC) begin
            epc <= mtc0_wdata;
        end
    end

    // BadVAddr: written only by the address-error exception actually selected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr <= '0;
        end else if (exc_taken && wr_badv_pc) begin
            badvaddr <= cur_pc;
        end else if (exc_taken && wr_badv_addr) begin
            badvaddr <= bad_addr;
        end
    end

    assign status_rd = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
    assign cause_rd  = {cause_bd, ti, 14'd0, ip, 1'b0, cause_code, 2'b00};

    // mfc0 read mux from current register contents (no write bypass)
    always_comb begin
        mfc0_rdata = 32'd0;
        case (cp0_addr)
            REG_BADVADDR: mfc0_rdata = badvaddr;
            REG_COUNT:    mfc0_rdata = count;
            REG_COMPARE:  mfc0_rdata = compare_rd;
            REG_STATUS:   mfc0_rdata = status_rd;
            REG_CAUSE:    mfc0_rdata = cause_rd;
            REG_EPC:      mfc0_rdata = epc;
            default:      mfc0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit (default parameters, COUNT_DIV=2).
module tb_cp0_exc_unit;

    localparam int HW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [HW-1:0] hw_int;
    logic          inst_valid;
    logic [6:0]    exc_vec;
    logic          is_eret;
    logic          in_delay_slot;
    logic [31:0]   cur_pc;
    logic [31:0]   bad_addr;
    logic          mtc0_we;
    logic [4:0]    cp0_addr;
    logic [31:0]   mtc0_wdata;
    logic [31:0]   mfc0_rdata;
    logic          flush;
    logic [31:0]   new_pc;
    logic          int_pending;

    int errors = 0;
    int checks = 0;

    cp0_exc_unit #(.HW_INT_NUM(HW), .COUNT_DIV(2), .EXC_VECTOR(32'hBFC00380)) dut (
        .clk(clk), .rst(rst), .hw_int(hw_int), .inst_valid(inst_valid),
        .exc_vec(exc_vec), .is_eret(is_eret), .in_delay_slot(in_delay_slot),
        .cur_pc(cur_pc), .bad_addr(bad_addr), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
        .mtc0_wdata(mtc0_wdata), .mfc0_rdata(mfc0_rdata), .flush(flush),
        .new_pc(new_pc), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_valid    = 1'b0;
        exc_vec       = '0;
        is_eret       = 1'b0;
        in_delay_slot = 1'b0;
        cur_pc        = '0;
        bad_addr      = '0;
        mtc0_we       = 1'b0;
        cp0_addr      = '0;
        mtc0_wdata    = '0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1;
        d = mfc0_rdata;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        inst_valid = 1'b1;
        mtc0_we    = 1'b1;
        cp0_addr   = a;
        mtc0_wdata = d;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        clear_inputs();
        hw_int = '0;
        rst    = 1'b0;
        tick();
        tick();
        checks++;
        if (flush !== 1'b0 || int_pending !== 1'b0 || new_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: flush=%b int_pending=%b new_pc=%h, want 0 0 0",
                     flush, int_pending, new_pc);
        end
        rst = 1'b1;
        rd(5'd12, d);
        checks++;
        if (d !== 32'h0040_0000) begin
            errors++; $display("FAIL reset_status: got %h want 00400000", d);
        end
        rd(5'd13, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL reset_cause: got %h want 00000000", d);
        end
        rd(5'd9, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %h want 00000000", d);
        end
    endtask

    task automatic test_count();
        logic [31:0] d;
        tick();
        rd(5'd9, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL count_after_1clk: got %h want 0", d);
        end
        tick();
        rd(5'd9, d);
        checks++;
        if (d !== 32'd1) begin
            errors++; $display("FAIL count_after_2clk: got %h want 1", d);
        end
        wr(5'd9, 32'd0);
        tick();
        tick();
        rd(5'd9, d);
        checks++;
        if (d !== 32'd1) begin
            errors++; $display("FAIL count_after_reload: got %h want 1", d);
        end
        wr(5'd9, 32'hFFFF_FFFF);
        tick();
        tick();
        rd(5'd9, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL count_wrap: got %h want 0", d);
        end
    endtask

    task automatic test_ov_delay_slot();
        logic [31:0] d;
        inst_valid    = 1'b1;
        exc_vec       = 7'b0010000;
        cur_pc        = 32'hBFC00100;
        in_delay_slot = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'hBFC00380) begin
            errors++; $display("FAIL ov_flush: flush=%b new_pc=%h want 1 bfc00380", flush, new_pc);
        end
        tick();
        clear_inputs();
        rd(5'd14, d);
        checks++;
        if (d !== 32'hBFC000FC) begin
            errors++; $display("FAIL ov_epc: got %h want bfc000fc", d);
        end
        rd(5'd13, d);
        checks++;
        if (d !== 32'h8000_0030) begin
            errors++; $display("FAIL ov_cause: got %h want 80000030", d);
        end
        rd(5'd12, d);
        checks++;
        if (d !== 32'h0040_0002) begin
            errors++; $display("FAIL ov_status: got %h want 00400002", d);
        end
        // Nested bp while EXL=1: EPC and BD held, code updated
        inst_valid = 1'b1;
        exc_vec    = 7'b0000100;
        cur_pc     = 32'hBFC00300;
        tick();
        clear_inputs();
        rd(5'd14, d);
        checks++;
        if (d !== 32'hBFC000FC) begin
            errors++; $display("FAIL nested_epc: got %h want bfc000fc", d);
        end
        rd(5'd13, d);
        checks++;
        if (d !== 32'h8000_0024) begin
            errors++; $display("FAIL nested_cause: got %h want 80000024", d);
        end
        wr(5'd12, 32'd0);
    endtask

    task automatic test_interrupt();
        logic [31:0] d;
        wr(5'd12, 32'h0000_FF01);
        hw_int[0] = 1'b1;
        #1;
        checks++;
        if (int_pending !== 1'b0) begin
            errors++; $display("FAIL int_latency: int_pending=%b want 0", int_pending);
        end
        tick();
        checks++;
        if (int_pending !== 1'b1) begin
            errors++; $display("FAIL int_pending: int_pending=%b want 1", int_pending);
        end
        inst_valid = 1'b1;
        cur_pc     = 32'hBFC00010;
        #1;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'hBFC00380) begin
            errors++; $display("FAIL int_flush: flush=%b new_pc=%h want 1 bfc00380", flush, new_pc);
        end
        tick();
        clear_inputs();
        rd(5'd13, d);
        checks++;
        if (d !== 32'h0000_0400) begin
            errors++; $display("FAIL int_cause: got %h want 00000400", d);
        end
        rd(5'd14, d);
        checks++;
        if (d !== 32'hBFC00010) begin
            errors++; $display("FAIL int_epc: got %h want bfc00010", d);
        end
        // EXL now 1: committing again must not trap
        inst_valid = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b0 || int_pending !== 1'b0) begin
            errors++; $display("FAIL int_masked_by_exl: flush=%b int_pending=%b want 0 0", flush, int_pending);
        end
        tick();
        clear_inputs();
        hw_int = '0;
        tick();
    endtask

    task automatic test_priority();
        logic [31:0] d;
        wr(5'd12, 32'd0);
        inst_valid = 1'b1;
        exc_vec    = 7'b0001001;
        bad_addr   = 32'h0000_1234;
        cur_pc     = 32'hBFC00020;
        tick();
        clear_inputs();
        rd(5'd13, d);
        checks++;
        if (d !== 32'h0000_0020) begin
            errors++; $display("FAIL sys_over_ades_cause: got %h want 00000020", d);
        end
        rd(5'd8, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL sys_over_ades_badv: got %h want 0", d);
        end
        wr(5'd12, 32'd0);
        // ades alone, with an mtc0 to EPC that must be suppressed
        inst_valid = 1'b1;
        exc_vec    = 7'b0000001;
        bad_addr   = 32'h0000_1234;
        cur_pc     = 32'hBFC00030;
        mtc0_we    = 1'b1;
        cp0_addr   = 5'd14;
        mtc0_wdata = 32'hDEADBEEF;
        tick();
        clear_inputs();
        rd(5'd13, d);
        checks++;
        if (d !== 32'h0000_0014) begin
            errors++; $display("FAIL ades_cause: got %h want 00000014", d);
        end
        rd(5'd8, d);
        checks++;
        if (d !== 32'h0000_1234) begin
            errors++; $display("FAIL ades_badv: got %h want 00001234", d);
        end
        rd(5'd14, d);
        checks++;
        if (d !== 32'hBFC00030) begin
            errors++; $display("FAIL mtc0_suppressed: epc=%h want bfc00030", d);
        end
        wr(5'd12, 32'd0);
        inst_valid = 1'b1;
        exc_vec    = 7'b1100000;
        cur_pc     = 32'hBFC00041;
        tick();
        clear_inputs();
        rd(5'd13, d);
        checks++;
        if (d !== 32'h0000_0010) begin
            errors++; $display("FAIL pc_adel_cause: got %h want 00000010", d);
        end
        rd(5'd8, d);
        checks++;
        if (d !== 32'hBFC00041) begin
            errors++; $display("FAIL pc_adel_badv: got %h want bfc00041", d);
        end
    endtask

    task automatic test_eret();
        logic [31:0] d;
        // mtc0 EPC: read in the same cycle still sees the old value
        inst_valid = 1'b1;
        mtc0_we    = 1'b1;
        cp0_addr   = 5'd14;
        mtc0_wdata = 32'hBFC00200;
        #1;
        checks++;
        if (mfc0_rdata !== 32'hBFC00041) begin
            errors++; $display("FAIL no_bypass: got %h want bfc00041", mfc0_rdata);
        end
        tick();
        clear_inputs();
        inst_valid = 1'b1;
        is_eret    = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'hBFC00200) begin
            errors++; $display("FAIL eret_flush: flush=%b new_pc=%h want 1 bfc00200", flush, new_pc);
        end
        tick();
        clear_inputs();
        rd(5'd12, d);
        checks++;
        if (d !== 32'h0040_0000) begin
            errors++; $display("FAIL eret_exl: status=%h want 00400000", d);
        end
        inst_valid = 1'b1;
        is_eret    = 1'b1;
        exc_vec    = 7'b0100000;
        cur_pc     = 32'hBFC00050;
        #1;
        checks++;
        if (flush !== 1'b1 || new_pc !== 32'hBFC00380) begin
            errors++; $display("FAIL eret_ri_pc: flush=%b new_pc=%h want 1 bfc00380", flush, new_pc);
        end
        tick();
        clear_inputs();
        rd(5'd13, d);
        checks++;
        if (d !== 32'h0000_0028) begin
            errors++; $display("FAIL eret_ri_cause: got %h want 00000028", d);
        end
        rd(5'd12, d);
        checks++;
        if (d !== 32'h0040_0002) begin
            errors++; $display("FAIL eret_ri_status: got %h want 00400002", d);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        wr(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, d);
        checks++;
        if (d !== 32'h0000_0328) begin
            errors++; $display("FAIL cause_write_mask: got %h want 00000328", d);
        end
        wr(5'd8, 32'd0);
        rd(5'd8, d);
        checks++;
        if (d !== 32'hBFC00041) begin
            errors++; $display("FAIL badv_readonly: got %h want bfc00041", d);
        end
        wr(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, d);
        checks++;
        if (d !== 32'h0040_FF03) begin
            errors++; $display("FAIL status_write_mask: got %h want 0040ff03", d);
        end
        rd(5'd3, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL unmapped_read: got %h want 0", d);
        end
        wr(5'd12, 32'h0000_FF01);
        checks++;
        if (int_pending !== 1'b1) begin
            errors++; $display("FAIL sw_int_pending: int_pending=%b want 1", int_pending);
        end
        // Commit of mtc0 Cause=0 traps on the software interrupt; the write is dropped
        inst_valid = 1'b1;
        mtc0_we    = 1'b1;
        cp0_addr   = 5'd13;
        mtc0_wdata = 32'd0;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++; $display("FAIL sw_int_flush: flush=%b want 1", flush);
        end
        tick();
        clear_inputs();
        rd(5'd13, d);
        checks++;
        if (d !== 32'h0000_0300) begin
            errors++; $display("FAIL sw_int_cause: got %h want 00000300", d);
        end
        wr(5'd13, 32'd0);
        rd(5'd13, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL sw_ip_clear: got %h want 0", d);
        end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        logic [31:0] c;
        bit          seen;
`ifdef CP0_TIMER_EN
        seen = 1'b0;
        wr(5'd9, 32'd0);
        wr(5'd11, 32'd5);
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            rd(5'd13, d);
            if (d[30]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL timer_ti_timeout: TI never set within 40 clks");
        end
        rd(5'd9, c);
        checks++;
        if (c !== 32'd5 || d !== 32'h4000_8000) begin
            errors++; $display("FAIL timer_ti_set: count=%h cause=%h want 5 40008000", c, d);
        end
        wr(5'd11, 32'd5);
        rd(5'd13, d);
        checks++;
        if (d[30] !== 1'b0) begin
            errors++; $display("FAIL timer_ti_clear: cause=%h want TI=0", d);
        end
`else
        seen = 1'b0;
        wr(5'd11, 32'd5);
        rd(5'd11, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL compare_absent: got %h want 0", d);
        end
        wr(5'd9, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            rd(5'd13, c);
            if (c[30]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL ti_absent: TI observed set, want 0");
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        inst_valid = 1'b1;
        exc_vec    = 7'b0010000;
        #1;
        checks++;
        if (flush !== 1'b1) begin
            errors++; $display("FAIL mid_reset_pre: flush=%b want 1", flush);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (flush !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flush: flush=%b want 0", flush);
        end
        clear_inputs();
        rd(5'd12, d);
        checks++;
        if (d !== 32'h0040_0000) begin
            errors++; $display("FAIL mid_reset_status: got %h want 00400000", d);
        end
        rd(5'd14, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL mid_reset_epc: got %h want 0", d);
        end
        tick();
        rst = 1'b1;
    endtask

    initial begin
        hw_int = '0;
        clear_inputs();
        test_reset();
        test_count();
        test_ov_delay_slot();
        test_interrupt();
        test_priority();
        test_eret();
        test_regs();
        test_timer();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
